// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar egress port slice.
//   - default cell payload/control widths
//   - position of the destination-port field inside the control word
//   - statistics counter widths
//   - egress FSM state encoding
package xbar_pkg;

  localparam int DATA_WIDTH_DEF = 480;
  localparam int CTRL_WIDTH_DEF = 32;

  // Destination port field inside the control word
  localparam int DST_LSB = 0;
  localparam int DST_MSB = 1;

  // Statistics counter widths
  localparam int SAT_CNT_W = 16;  // drop / misroute, saturating
  localparam int FWD_CNT_W = 32;  // forwarded cells, wrapping

  // EMPTY : output register empty (out_valid=0)
  // HEAD  : output register loaded, buffer empty
  // STREAM: output register loaded, buffer holds further cells
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HEAD   = 2'd1,
    ST_STREAM = 2'd2
  } egress_state_e;

endpackage

// File: rtl/xbar_egress_fifo.sv
// Circular cell buffer behind the egress output register.
// Ports:
//   clk, rst       clock, asynchronous active-low reset (pointers only)
//   wr_en, wr_data append one cell at the tail
//   rd_en, rd_data rd_data always shows the head; rd_en advances it
// The owner tracks fill level and never writes a full buffer or reads an
// empty one, so the buffer itself keeps no count.
module xbar_egress_fifo
  import xbar_pkg::*;
#(
  parameter int WIDTH      = DATA_WIDTH_DEF + CTRL_WIDTH_DEF,
  parameter int DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;

  // Pointers are exactly DEPTH_BITS wide, so increment wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible behind a valid pointer.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/xbar_egress_port.sv
// Crossbar egress port: captures cells addressed to PORT_ID, buffers them
// and presents them downstream through a registered valid/ready output.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_wr, in_ctl, in_data   crossbar write strobe (no backpressure) + cell
//   out_valid, out_ready,
//   out_ctl, out_data        downstream cell handshake
//   occupancy                cells held (output register + buffer), 0..DEPTH
//   clr_stats                synchronous clear of all counters
//   drop_cnt, misroute_cnt   saturating event counters
//   fwd_cnt                  wrapping delivered-cell counter
//   fsm_state                current EMPTY/HEAD/STREAM state (debug)
//
// Handshake: a cell transfers on every rising edge where out_valid and
// out_ready are both 1. out_valid never drops and out_ctl/out_data never
// change while out_valid=1 and out_ready=0.
module xbar_egress_port
  import xbar_pkg::*;
#(
  parameter int         DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int         CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int         DEPTH_BITS = 3,
  parameter logic [1:0] PORT_ID    = 2'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_wr,
  input  logic [CTRL_WIDTH-1:0] in_ctl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEPTH_BITS:0]   occupancy,
  input  logic                  clr_stats,
  output logic [SAT_CNT_W-1:0]  drop_cnt,
  output logic [SAT_CNT_W-1:0]  misroute_cnt,
  output logic [FWD_CNT_W-1:0]  fwd_cnt,
  output egress_state_e         fsm_state
);

  localparam int CELL_W = CTRL_WIDTH + DATA_WIDTH;
  localparam int DEPTH  = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] OCC_MAX = DEPTH_BITS'(0) + (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] OCC_TWO = (DEPTH_BITS+1)'(2);

  egress_state_e state_q, state_d;

  logic              match, full, pop, push_req, push, drop, misroute;
  logic              load_in, fifo_wr, fifo_rd;
  logic [CELL_W-1:0] fifo_head;

  assign match    = (in_ctl[DST_MSB:DST_LSB] == PORT_ID);
  assign full     = (occupancy == OCC_MAX);
  assign pop      = out_valid & out_ready;
  assign push_req = in_wr & match;
  // A full port still accepts when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign misroute = in_wr & ~match;

  // Next state and datapath steering. A cell bypasses the buffer and goes
  // straight into the output register whenever the register is (or is
  // becoming) free and the buffer is empty; this keeps FIFO order.
  always_comb begin
    state_d = state_q;
    load_in = 1'b0;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          load_in = 1'b1;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (pop && push) begin
          load_in = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end else if (push) begin
          fifo_wr = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        fifo_wr = push;
        fifo_rd = pop;
        // Last buffered cell moves into the output register.
        if (pop && !push && occupancy == OCC_TWO) state_d = ST_HEAD;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      out_valid <= 1'b0;
      out_ctl   <= '0;
      out_data  <= '0;
      occupancy <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != ST_EMPTY);
      occupancy <= occupancy + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop);
      if (load_in) begin
        out_ctl  <= in_ctl;
        out_data <= in_data;
      end else if (fifo_rd) begin
        {out_ctl, out_data} <= fifo_head;
      end
    end
  end

  // Statistics; clr_stats wins over any same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt     <= '0;
      misroute_cnt <= '0;
      fwd_cnt      <= '0;
    end else if (clr_stats) begin
      drop_cnt     <= '0;
      misroute_cnt <= '0;
      fwd_cnt      <= '0;
    end else begin
      if (drop && drop_cnt != '1)         drop_cnt     <= drop_cnt + 1'b1;
      if (misroute && misroute_cnt != '1) misroute_cnt <= misroute_cnt + 1'b1;
      if (pop)                            fwd_cnt      <= fwd_cnt + 1'b1;
    end
  end

  assign fsm_state = state_q;

  xbar_egress_fifo #(
    .WIDTH      (CELL_W),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({in_ctl, in_data}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head)
  );

endmodule

// File: tb/tb_xbar_egress_port.sv
// Bench for xbar_egress_port (PORT_ID=2, 64-bit payload). A queue-based
// model tracks accepted cells and counters from the port's rules; a compare
// process checks every output against it on each falling edge, and directed
// literal checks pin the model in the named scenarios.
module tb_xbar_egress_port;
  import xbar_pkg::*;

  localparam int         DW  = 64;
  localparam int         CW  = 32;
  localparam int         DB  = 3;
  localparam int         DEP = 8;
  localparam logic [1:0] PID = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_wr = 1'b0;
  logic [CW-1:0] in_ctl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          clr_stats = 1'b0;
  logic          out_valid;
  logic [CW-1:0] out_ctl;
  logic [DW-1:0] out_data;
  logic [DB:0]   occupancy;
  logic [15:0]   drop_cnt, misroute_cnt;
  logic [31:0]   fwd_cnt;
  egress_state_e fsm_state;

  xbar_egress_port #(
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .DEPTH_BITS (DB),
    .PORT_ID    (PID)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_wr        (in_wr),
    .in_ctl       (in_ctl),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctl      (out_ctl),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .clr_stats    (clr_stats),
    .drop_cnt     (drop_cnt),
    .misroute_cnt (misroute_cnt),
    .fwd_cnt      (fwd_cnt),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [CW+DW-1:0] exp_q[$];
  int          m_drop = 0;
  int          m_mis  = 0;
  logic [31:0] m_fwd  = '0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          checking = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Effect of one rising edge on the model, given the inputs held across it.
  task automatic model_edge(input logic wr, input logic [CW-1:0] ctl,
                            input logic [DW-1:0] data, input logic rdy, input logic clr);
    bit pop, acc;
    pop = (exp_q.size() > 0) && rdy;
    acc = 1'b0;
    if (wr) begin
      if (ctl[1:0] != PID) begin
        if (!clr && m_mis < 65535) m_mis++;
      end else if (exp_q.size() < DEP || pop) begin
        acc = 1'b1;
      end else if (!clr && m_drop < 65535) begin
        m_drop++;
      end
    end
    if (clr) begin
      m_drop = 0;
      m_mis  = 0;
      m_fwd  = '0;
    end else if (pop) begin
      m_fwd = m_fwd + 32'd1;
    end
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({ctl, data});
  endtask

  // Compare process: outputs have settled since the previous rising edge.
  always @(negedge clk) begin
    if (checking) begin
      egress_state_e es;
      es = (exp_q.size() == 0) ? ST_EMPTY : (exp_q.size() == 1) ? ST_HEAD : ST_STREAM;
      chk("occupancy", occupancy, exp_q.size());
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("fsm_state", fsm_state, es);
      if (exp_q.size() != 0) begin
        chk("out_ctl", out_ctl, exp_q[0][CW+DW-1:DW]);
        chk("out_data", out_data, exp_q[0][DW-1:0]);
      end
      chk("drop_cnt", drop_cnt, m_drop);
      chk("misroute_cnt", misroute_cnt, m_mis);
      chk("fwd_cnt", fwd_cnt, m_fwd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic wr, input logic [CW-1:0] ctl, input logic [DW-1:0] data,
                     input logic rdy, input logic clr);
    @(negedge clk);
    #1;
    in_wr = wr; in_ctl = ctl; in_data = data; out_ready = rdy; clr_stats = clr;
    if (rst) model_edge(wr, ctl, data, rdy, clr);
  endtask

  // Sample just after the rising edge that follows the last cyc().
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drain();
    for (int i = 0; i < 4 * DEP && exp_q.size() != 0; i++) cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctl", out_ctl, 0);
    chk("rst_fwd_cnt", fwd_cnt, 0);
    #1 rst = 1'b1;
    checking = 1'b1;

    // Single cell, one-cycle latency
    cyc(1, 32'h2, 64'hA5, 0, 0);
    after_edge();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 64'hA5);
    cyc(0, '0, '0, 1, 0);
    after_edge();
    chk("single_fwd", fwd_cnt, 1);
    chk("single_occ", occupancy, 0);
    cyc(0, '0, '0, 0, 0);

    // Misroute
    cyc(1, 32'h3, 64'h77, 0, 0);
    after_edge();
    chk("misroute_cnt_lit", misroute_cnt, 1);
    chk("misroute_valid", out_valid, 0);

    // Overflow: 10 cells, ready low
    for (int i = 0; i < 10; i++) cyc(1, 32'h2 | (i << 8), rnd_data(), 0, 0);
    after_edge();
    chk("ovf_occ", occupancy, 8);
    chk("ovf_drop", drop_cnt, 2);
    // Full push + pop in the same cycle
    cyc(1, 32'h2 | (32'h55 << 8), rnd_data(), 1, 0);
    after_edge();
    chk("fullpp_occ", occupancy, 8);
    chk("fullpp_drop", drop_cnt, 2);
    chk("fullpp_head", out_ctl, 32'h0000_0102);
    drain();

    // Streaming with out_ready toggling 1010
    for (int i = 0; i < 20; i++) cyc(1, 32'h2 | (i << 8), rnd_data(), (i % 2) == 0, 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(0, '0, '0, (i % 2) == 0, 0);
    cyc(0, '0, '0, 0, 1);
    // Throughput: 3 queued, then push+pop every cycle for 10 cycles
    for (int i = 0; i < 3; i++) cyc(1, 32'h2, rnd_data(), 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'h2 | (i << 8), rnd_data(), 1, 0);
    after_edge();
    chk("thru_fwd", fwd_cnt, 10);
    chk("thru_occ", occupancy, 3);
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [CW-1:0] c;
      c = $urandom();
      if ($urandom_range(0, 3) != 0) c[1:0] = PID;
      cyc($urandom_range(0, 2) != 0, c, rnd_data(), $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1,
          $urandom_range(0, 199) == 0);
    end
    drain();

    // Asynchronous reset with 5 cells held; writes during reset are ignored
    for (int i = 0; i < 5; i++) cyc(1, 32'h2, rnd_data(), 0, 0);
    @(negedge clk);
    #3;
    rst = 1'b0;
    in_wr = 1'b1; in_ctl = 32'h2; out_ready = 1'b0;
    exp_q.delete();
    m_drop = 0; m_mis = 0; m_fwd = '0;
    #1;
    chk("arst_occ", occupancy, 0);
    chk("arst_valid", out_valid, 0);
    repeat (2) cyc(1, 32'h3, rnd_data(), 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    in_wr = 1'b0;
    cyc(1, 32'h2, 64'hBEEF, 0, 0);
    after_edge();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 64'hBEEF);
    chk("post_rst_mis", misroute_cnt, 0);

    // drop_cnt saturation, then clear overriding a same-cycle drop
    for (int i = 0; i < 7; i++) cyc(1, 32'h2, rnd_data(), 0, 0);
    for (int i = 0; i < 65538; i++) cyc(1, 32'h2, '0, 0, 0);
    after_edge();
    chk("sat_drop", drop_cnt, 16'hFFFF);
    cyc(1, 32'h2, '0, 0, 0);
    after_edge();
    chk("sat_hold", drop_cnt, 16'hFFFF);
    cyc(1, 32'h2, '0, 0, 1);
    after_edge();
    chk("clr_drop", drop_cnt, 0);
    chk("clr_fwd", fwd_cnt, 0);
    cyc(0, '0, '0, 0, 0);
    drain();

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
